// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding, mode constants and counter sizing for the TX/RX shifters
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} spi_state_e;
  localparam int CPHA0 = 0;
  localparam int CPHA1 = 1;
  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;
  function automatic int spi_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/spi_tx_holdbuf.sv
// spi_tx_holdbuf: one-entry valid/ready holding register with a consume strobe
module spi_tx_holdbuf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_valid_i,
  output logic         wr_ready_o,
  output logic [W-1:0] rd_data_o,
  output logic         rd_full_o,
  input  logic         rd_consume_i
);
  logic         full_q, full_d, accept;
  logic [W-1:0] data_q, data_d;
  assign accept     = wr_valid_i && !full_q;
  assign full_d     = accept || (full_q && !rd_consume_i);
  assign data_d     = accept ? wr_data_i : data_q;
  assign wr_ready_o = !full_q;
  assign rd_data_o  = data_q;
  assign rd_full_o  = full_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/spi_slave_tx_shifter.sv
// spi_slave_tx_shifter: SPI slave MISO shifter with holding buffer, CPHA 0/1 and bit-order options.
// Define SPI_TX_PARITY_EN to append an even-parity bit after each word.
module spi_slave_tx_shifter
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   CPHA       = 0,
  parameter int   LSB_FIRST  = 0,
  parameter logic IDLE_VAL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  cs_n,
  input  logic                  shift_stb,
  output logic                  dout,
  output logic                  dout_oe,
  output logic                  done,
  output logic                  underrun,
  output logic                  abort
);
  localparam int CW = spi_cnt_w(DATA_WIDTH);
`ifdef SPI_TX_PARITY_EN
  localparam int NB = DATA_WIDTH + 1;
`else
  localparam int NB = DATA_WIDTH;
`endif
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{IDLE_VAL}};
  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, buf_data, load_word, sh_next;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  oe_q, done_q, done_d, underrun_q, underrun_d, abort_q, abort_d;
  logic                  buf_full, load, sh_bit;
  spi_tx_holdbuf #(.W(DATA_WIDTH)) u_holdbuf (
    .clk         (clk),
    .rst         (rst),
    .wr_data_i   (tx_data),
    .wr_valid_i  (tx_valid),
    .wr_ready_o  (tx_ready),
    .rd_data_o   (buf_data),
    .rd_full_o   (buf_full),
    .rd_consume_i(load)
  );
  assign load_word = buf_full ? buf_data : IDLE_WORD;
  assign sh_next   = (LSB_FIRST == ORDER_LSB_FIRST) ? {IDLE_VAL, sh_q[DATA_WIDTH-1:1]}
                                                    : {sh_q[DATA_WIDTH-2:0], IDLE_VAL};
  assign sh_bit    = (LSB_FIRST == ORDER_MSB_FIRST) ? sh_q[DATA_WIDTH-1] : sh_q[0];
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;
    if (cs_n) begin
      state_d = IDLE;
      abort_d = (state_q == SHIFT) && (cnt_q != '0);
    end else if (state_q == IDLE) begin
      state_d = (CPHA == CPHA1) ? ARMED : SHIFT;
      load    = (CPHA == CPHA0);
    end else if (shift_stb) begin
      if (state_q == ARMED) begin
        state_d = SHIFT;
        load    = 1'b1;
      end else if (cnt_q == CW'(NB - 1)) begin
        // the strobe consuming the last bit either chains the next word or re-arms
        done_d  = 1'b1;
        cnt_d   = '0;
        load    = (CPHA == CPHA0);
        state_d = (CPHA == CPHA0) ? SHIFT : ARMED;
      end else begin
        sh_d  = sh_next;
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (load) begin
      sh_d       = load_word;
      cnt_d      = '0;
      underrun_d = !buf_full;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sh_q       <= IDLE_WORD;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      oe_q       <= !cs_n;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end
`ifdef SPI_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else if (load) par_q <= ^load_word;
  end
  assign dout = (state_q == SHIFT) ? ((cnt_q == CW'(DATA_WIDTH)) ? par_q : sh_bit) : IDLE_VAL;
`else
  assign dout = (state_q == SHIFT) ? sh_bit : IDLE_VAL;
`endif
  assign dout_oe  = oe_q;
  assign done     = done_q;
  assign underrun = underrun_q;
  assign abort    = abort_q;
endmodule

// File: tb/tb_spi_slave_tx_shifter.sv
// tb_spi_slave_tx_shifter: directed and random checks of a CPHA0/MSB and a CPHA1/LSB instance against a word-level model
module tb_spi_slave_tx_shifter;
  localparam int DW = 8;
`ifdef SPI_TX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] tx_valid = '0, cs_n = '1, stb = '0;
  logic [1:0][DW-1:0] tx_data = '0;
  logic [1:0] tx_ready, dout, oe, done, urun, abrt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  spi_slave_tx_shifter #(.DATA_WIDTH(DW), .CPHA(0), .LSB_FIRST(0), .IDLE_VAL(1'b1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .cs_n(cs_n[0]), .shift_stb(stb[0]), .dout(dout[0]), .dout_oe(oe[0]), .done(done[0]),
    .underrun(urun[0]), .abort(abrt[0]));
  spi_slave_tx_shifter #(.DATA_WIDTH(DW), .CPHA(1), .LSB_FIRST(1), .IDLE_VAL(1'b1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .cs_n(cs_n[1]), .shift_stb(stb[1]), .dout(dout[1]), .dout_oe(oe[1]), .done(done[1]),
    .underrun(urun[1]), .abort(abrt[1]));
  // model: buffered word, word in flight as a bit list indexed by strobes since load
  bit m_cpha[2] = '{1'b0, 1'b1};
  bit m_lsb[2]  = '{1'b0, 1'b1};
  bit bv[2], busy[2], infr[2], e_done[2], e_urun[2], e_abrt[2], e_oe[2];
  logic [DW-1:0] bw[2], wd[2];
  int pos[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic tx_bit(input int m);
    if (!busy[m]) return 1'b1;
    if (pos[m] >= DW) return ^wd[m];
    return m_lsb[m] ? wd[m][pos[m]] : wd[m][DW-1-pos[m]];
  endfunction
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      bv[m] = 0; busy[m] = 0; infr[m] = 0; pos[m] = 0;
      e_done[m] = 0; e_urun[m] = 0; e_abrt[m] = 0; e_oe[m] = 0;
    end
  endtask
  task automatic model_step(input int m);
    bit ld, acc;
    ld = 0;
    e_done[m] = 0; e_urun[m] = 0; e_abrt[m] = 0;
    acc = tx_valid[m] && !bv[m];
    if (cs_n[m]) begin
      e_abrt[m] = busy[m] && pos[m] > 0;
      busy[m] = 0; infr[m] = 0;
    end else if (!infr[m]) begin
      infr[m] = 1; ld = !m_cpha[m];
    end else if (stb[m]) begin
      if (!busy[m]) ld = 1;
      else if (pos[m] == NB - 1) begin
        e_done[m] = 1; busy[m] = 0; ld = !m_cpha[m];
      end else pos[m] = pos[m] + 1;
    end
    if (ld) begin
      e_urun[m] = !bv[m];
      wd[m] = bv[m] ? bw[m] : '1;
      bv[m] = 0; busy[m] = 1; pos[m] = 0;
    end
    if (acc) begin bv[m] = 1; bw[m] = tx_data[m]; end
    e_oe[m] = !cs_n[m];
  endtask
  task automatic check_outs();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dout%0d", m), dout[m], tx_bit(m));
      check($sformatf("oe%0d", m), oe[m], e_oe[m]);
      check($sformatf("done%0d", m), done[m], e_done[m]);
      check($sformatf("urun%0d", m), urun[m], e_urun[m]);
      check($sformatf("abort%0d", m), abrt[m], e_abrt[m]);
      check($sformatf("ready%0d", m), tx_ready[m], !bv[m]);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m);
    #1;
    check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #2;
    tx_valid = '0; cs_n = '1; stb = '0;
    model_reset();
    check("rst_ready", tx_ready, 2'b11);
    check("rst_dout", dout, 2'b11);
    check("rst_oe", oe, 2'b00);
    check("rst_pulses", {done, urun, abrt}, 6'b0);
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  logic [DW-1:0] pat;
  logic [2*DW-1:0] seq;
  int n_done, n_urun;
  initial begin
    do_reset();
    // CPHA0 MSB-first single word
    pat = 8'hA5;
    tx_data[0] = pat; tx_valid[0] = 1; cycle(); tx_valid[0] = 0;
    check("a5_full", tx_ready[0], 1'b0);
    cs_n[0] = 0; cycle();
    check("a5_ready", tx_ready[0], 1'b1);
    for (int i = 0; i < NB; i++) begin
      if (i < DW) check("a5_bit", dout[0], pat[DW-1-i]);
      stb[0] = 1; cycle(); stb[0] = 0;
      check("a5_done", done[0], i == NB - 1);
    end
    cs_n[0] = 1; cycle();
    // CPHA1 LSB-first single word
    pat = 8'h3C;
    tx_data[1] = pat; tx_valid[1] = 1; cs_n[1] = 0; cycle(); tx_valid[1] = 0;
    cycle();
    check("c1_armed", dout[1], 1'b1);
    for (int i = 0; i < NB; i++) begin
      stb[1] = 1; cycle(); stb[1] = 0;
      if (i < DW) check("c1_bit", dout[1], pat[i]);
      check("c1_nodone", done[1], 1'b0);
    end
    stb[1] = 1; cycle(); stb[1] = 0;
    check("c1_done", done[1], 1'b1);
    check("c1_rearm", dout[1], 1'b1);
    cs_n[1] = 1; cycle();
    // back-to-back words in one frame
    tx_data[0] = 8'h81; tx_valid[0] = 1; cycle();
    tx_data[0] = 8'h7E; cs_n[0] = 0; cycle(); cycle(); tx_valid[0] = 0;
    seq = '0; n_done = 0; n_urun = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i % NB < DW) seq = {seq[2*DW-2:0], dout[0]};
      stb[0] = 1; cycle(); stb[0] = 0;
      n_done += done[0];
      if (i < 2 * NB - 1) n_urun += urun[0];
    end
    check("b2b_seq", seq, 16'h817E);
    check("b2b_done", n_done, 2);
    check("b2b_urun", n_urun, 0);
    cs_n[0] = 1; cycle();
    // underrun frame
    cs_n[0] = 0; cycle();
    check("ur_pulse", urun[0], 1'b1);
    for (int i = 0; i < NB; i++) begin
      if (i < DW) check("ur_bit", dout[0], 1'b1);
      stb[0] = 1; cycle(); stb[0] = 0;
      check("ur_done", done[0], i == NB - 1);
    end
    cs_n[0] = 1; cycle();
    // abort with a queued word
    tx_data[0] = 8'hF0; tx_valid[0] = 1; cycle();
    tx_data[0] = 8'h55; cs_n[0] = 0; cycle(); cycle(); tx_valid[0] = 0;
    for (int i = 0; i < 3; i++) begin stb[0] = 1; cycle(); stb[0] = 0; end
    cs_n[0] = 1; cycle();
    check("ab_pulse", abrt[0], 1'b1);
    check("ab_dout", dout[0], 1'b1);
    check("ab_oe", oe[0], 1'b0);
    cs_n[0] = 0; cycle();
    check("ab_next_urun", urun[0], 1'b0);
    check("ab_next_bit", dout[0], 1'b0);
    stb[0] = 1; cycle(); stb[0] = 0;
    check("ab_next_bit1", dout[0], 1'b1);
    cs_n[0] = 1; cycle();
    // word 0x07, parity bit when enabled
    pat = 8'h07;
    tx_data[0] = pat; tx_valid[0] = 1; cycle(); tx_valid[0] = 0;
    cs_n[0] = 0; cycle();
    for (int i = 0; i < DW; i++) begin
      check("w07_bit", dout[0], pat[DW-1-i]);
      stb[0] = 1; cycle(); stb[0] = 0;
    end
`ifdef SPI_TX_PARITY_EN
    check("w07_par", dout[0], 1'b1);
`endif
    cs_n[0] = 1; cycle();
    // reset mid-word after 4 strobes
    tx_data[0] = 8'hC3; tx_valid[0] = 1; cycle(); tx_valid[0] = 0;
    cs_n[0] = 0; cycle();
    for (int i = 0; i < 4; i++) begin stb[0] = 1; cycle(); stb[0] = 0; end
    do_reset();
    cycle();
    check("post_rst_done", done, 2'b00);
    check("post_rst_abort", abrt, 2'b00);
    // random traffic on both instances
    for (int n = 0; n < 4000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 39) == 0) cs_n[m] = ~cs_n[m];
        stb[m] = ($urandom_range(0, 2) == 0);
        tx_valid[m] = ($urandom_range(0, 3) == 0);
        tx_data[m] = DW'($urandom);
      end
      cycle();
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
